irq_controller: RTL
===================

# irq_controller

Parametrised, vectored interrupt controller that sits between peripheral interrupt sources and the multicycle processor's INT/NMI/INTD/INA interrupt pins. It replaces single-line interrupt signalling with NUM_IRQ maskable channels, per-channel edge/level mode, fixed priority and a non-maskable channel. It presents one request at a time with a vector the processor reads on acknowledge, and tracks in-service state until end-of-interrupt.

## Interface
- NUM_IRQ, 8: maskable channels (2..32); channel 0 is highest priority.
- VEC_W, 8: vector width on INTD; must be ≥ clog2(NUM_IRQ)+1.
- NMI_VEC, all-ones: vector driven for NMI.

- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- irq  in  NUM_IRQ  raw peripheral requests, synchronous to clk.
- nmi_in  in  1  non-maskable request; rising-edge sensitive.
- cfg_we  in  1  write strobe for mask/mode registers.
- cfg_sel  in  1  0 = mask register, 1 = mode register.
- cfg_wdata  in  NUM_IRQ  register write data.
- INA  in  1  processor acknowledge, one-cycle pulse.
- eoi  in  1  end-of-interrupt pulse from processor.
- INT  out  1  maskable request to processor.
- NMI  out  1  non-maskable request to processor.
- INTD  out  VEC_W  vector of the acknowledged request.
- busy  out  1  a maskable interrupt is in service.

## Operation
- Mask register: bit = 1 enables channel. Mode register: bit = 1 edge (rising), 0 level. Both reset to 0 (all masked, all level).
- Pending: edge channels set pending on 0→1 of irq (previous-value register per channel); cleared when that channel is acknowledged. Level channels: pending = irq, sampled each cycle, no latch.
- Masked channels still latch edge-pending; they become eligible when unmasked.
- Eligible = pending & mask. Winner = lowest-index eligible channel.
- NMI: rising edge of nmi_in sets nmi_pend; NMI = nmi_pend. INA while NMI=1 acknowledges NMI first: clears nmi_pend, INTD = NMI_VEC. NMI never enters in-service state and needs no eoi.
- Maskable FSM:
  - IDLE: INT=0. Any eligible channel → REQ, latch winner index.
  - REQ: INT=1. Winner re-evaluated each cycle (a higher-priority arrival replaces it). Eligible set empty (level drops, mask cleared) → IDLE. INA with NMI=0 → SERVICE: INTD = {0, index}, clear that edge-pending bit, busy=1.
  - SERVICE: INT=0 regardless of new requests (no nesting). eoi → IDLE.
- INTD holds the last acknowledged vector until the next acknowledge.
- eoi outside SERVICE ignored. INA in IDLE with NMI=0 ignored, INTD unchanged.
- cfg_we takes effect the cycle after the write.

## Timing
- Reset values: INT=0, NMI=0, INTD=0, busy=0, FSM=IDLE, all pending, prev-irq, nmi_pend, mask, mode = 0.
- Edge irq at cycle t: pending set at t+1; INT high at t+2 when IDLE and unmasked.
- Level irq: INT high one cycle after assertion.
- INA at cycle t: INTD valid and busy high at t+1; INT low at t+1.
- eoi at t: IDLE at t+1; a still-eligible request raises INT at t+2.
- nmi_in rising at t: NMI high at t+1; NMI and INT may both be high.
- Simultaneous edge on channel k and ack of channel k: ack clears, new edge re-sets pending (set wins).
- Reset mid-service discards all state; no acknowledge is replayed.

## Structure
- Shared package irq_pkg: state enum (IDLE, REQ, SERVICE), NMI_VEC default, vector-construction function.
- One sub-module: irq_prio_enc (NUM_IRQ-wide combinational priority encoder → valid + index).
- Edge detection, pending, config registers and FSM in the top.

## Test plan
- Reset, mask=0xFF, mode=0xFF, edge on irq[5] → INT at +2 cycles; INA → INTD=0x05, busy=1, INT=0; eoi → busy=0.
- irq[6] and irq[2] edges together → INTD=0x02 on first INA; after eoi INT returns, second INA → INTD=0x06.
- Level irq[3] asserted then dropped before INA → INT falls, FSM back to IDLE, INTD unchanged.
- In SERVICE for irq[1], nmi_in rising → NMI=1; INA → INTD=0xFF, NMI=0, busy stays 1; eoi → IDLE.
- irq[4] edge with mask bit clear → INT stays 0; write mask bit 4 → INT=1 two cycles after cfg_we.
- Reset asserted during SERVICE with pending edges → all outputs 0 next cycle, no INT afterward without new edges.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types, defaults and vector helper for the vectored interrupt controller.
package irq_pkg;

    localparam int unsigned NUM_IRQ_DEF = 8;
    localparam int unsigned VEC_W_DEF   = 8;
    localparam int unsigned IDX_MAX_W   = 5;
    localparam logic [31:0] NMI_VEC_ALL = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;

    // Maskable vector: zero-extended channel index (callers narrow to VEC_W).
    function automatic logic [31:0] make_vec(input logic [IDX_MAX_W-1:0] idx);
        return 32'(idx);
    endfunction

endpackage

// File: rtl/irq_controller_if.sv
// Peripheral/config/processor-pin bundle for the interrupt controller.
interface irq_controller_if
    import irq_pkg::*;
#(
    parameter int unsigned NUM_IRQ = NUM_IRQ_DEF,
    parameter int unsigned VEC_W   = VEC_W_DEF
);
    logic [NUM_IRQ-1:0] irq;
    logic               nmi_in;
    logic               cfg_we;
    logic               cfg_sel;
    logic [NUM_IRQ-1:0] cfg_wdata;
    logic               INA;
    logic               eoi;
    logic               INT;
    logic               NMI;
    logic [VEC_W-1:0]   INTD;
    logic               busy;

    modport master (
        output irq, nmi_in, cfg_we, cfg_sel, cfg_wdata, INA, eoi,
        input  INT, NMI, INTD, busy
    );

    modport slave (
        input  irq, nmi_in, cfg_we, cfg_sel, cfg_wdata, INA, eoi,
        output INT, NMI, INTD, busy
    );
endinterface

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set index wins.
module irq_prio_enc #(
    parameter  int unsigned N     = 8,
    localparam int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    output logic             valid_o_c,
    output logic [IDX_W-1:0] idx_o_c
);
    // Scan from the top so the lowest active index is the last assignment.
    always_comb begin
        valid_o_c = |req_i;
        idx_o_c   = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req_i[i]) idx_o_c = IDX_W'(i);
        end
    end
endmodule

// File: rtl/irq_controller.sv
// Vectored interrupt controller: maskable edge/level channels with fixed
// priority, a rising-edge NMI, and in-service tracking until end-of-interrupt.
module irq_controller
    import irq_pkg::*;
#(
    parameter int unsigned      NUM_IRQ = NUM_IRQ_DEF,
    parameter int unsigned      VEC_W   = VEC_W_DEF,
    parameter logic [VEC_W-1:0] NMI_VEC = VEC_W'(NMI_VEC_ALL)
) (
    input logic            clk,
    input logic            reset,
    irq_controller_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(NUM_IRQ);

    irq_state_e         state_q, state_d;
    logic [NUM_IRQ-1:0] mask_q, mode_q, pend_q, pend_d, prev_q;
    logic               nmi_prev_q, nmi_pend_q, nmi_pend_d;
    logic               int_q, int_d, busy_q, busy_d;
    logic [VEC_W-1:0]   intd_q, intd_d;
    logic [NUM_IRQ-1:0] rise_c, elig_c, ack_clr_c;
    logic               enc_valid_c;
    logic [IDX_W-1:0]   enc_idx_c;
    logic               ack_c, nmi_ack_c;

    // Edge channels use the latched pending bit; level channels follow irq live.
    assign rise_c = bus.irq & ~prev_q;
    assign elig_c = ((mode_q & pend_q) | (~mode_q & bus.irq)) & mask_q;

    irq_prio_enc #(.N(NUM_IRQ)) u_enc (
        .req_i     (elig_c),
        .valid_o_c (enc_valid_c),
        .idx_o_c   (enc_idx_c)
    );

    // NMI takes the acknowledge first; a maskable ack needs REQ and no NMI.
    assign nmi_ack_c = bus.INA && nmi_pend_q;
    assign ack_c     = (state_q == REQ) && bus.INA && !nmi_pend_q && enc_valid_c;
    assign ack_clr_c = ack_c ? (NUM_IRQ'(1) << enc_idx_c) : '0;

    // A new edge in the same cycle as its ack re-arms the channel.
    assign pend_d     = ((pend_q & ~ack_clr_c) | rise_c) & mode_q;
    assign nmi_pend_d = (nmi_pend_q & ~nmi_ack_c) | (bus.nmi_in & ~nmi_prev_q);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (enc_valid_c) state_d = REQ;
            REQ: begin
                if (ack_c)             state_d = SERVICE;
                else if (!enc_valid_c) state_d = IDLE;
            end
            SERVICE: if (bus.eoi) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM output logic: next values of the registered processor pins.
    always_comb begin
        int_d  = 1'b0;
        busy_d = 1'b0;
        intd_d = intd_q;
        int_d  = (state_d == REQ);
        busy_d = (state_d == SERVICE);
        if (nmi_ack_c)  intd_d = NMI_VEC;
        else if (ack_c) intd_d = VEC_W'(make_vec(IDX_MAX_W'(enc_idx_c)));
    end

    // Registered processor-facing outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            int_q  <= 1'b0;
            busy_q <= 1'b0;
            intd_q <= '0;
        end else begin
            int_q  <= int_d;
            busy_q <= busy_d;
            intd_q <= intd_d;
        end
    end

    // Edge history, pending state and config registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q     <= '0;
            pend_q     <= '0;
            nmi_prev_q <= 1'b0;
            nmi_pend_q <= 1'b0;
            mask_q     <= '0;
            mode_q     <= '0;
        end else begin
            prev_q     <= bus.irq;
            pend_q     <= pend_d;
            nmi_prev_q <= bus.nmi_in;
            nmi_pend_q <= nmi_pend_d;
            if (bus.cfg_we) begin
                if (bus.cfg_sel) mode_q <= bus.cfg_wdata;
                else             mode_q <= mode_q;
                if (!bus.cfg_sel) mask_q <= bus.cfg_wdata;
                else              mask_q <= mask_q;
            end
        end
    end

    assign bus.INT  = int_q;
    assign bus.NMI  = nmi_pend_q;
    assign bus.INTD = intd_q;
    assign bus.busy = busy_q;

endmodule
